// File: rtl/regfile_mp_swc_if.sv
// Decode-side bundle for the multi-port register file: write, read, scoreboard set,
// registered read responses, clear-engine status and the array shadow.
interface regfile_mp_swc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic                     reg_wen;
  logic [ADDR_W-1:0]        reg_waddr;
  logic [DATA_W-1:0]        reg_wdata;
  logic [NUM_RD-1:0]        reg_ren;
  logic [NUM_RD*ADDR_W-1:0] reg_raddr;
  logic [NUM_RD*DATA_W-1:0] reg_rdata;
  logic [NUM_RD-1:0]        reg_rvalid;
  logic [NUM_RD-1:0]        reg_pending;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     init_busy;
  logic [DEPTH*DATA_W-1:0]  regfile_interact;

  modport master (
    output reg_wen, reg_waddr, reg_wdata, reg_ren, reg_raddr, sb_set, sb_addr,
    input  reg_rdata, reg_rvalid, reg_pending, init_busy, regfile_interact
  );

  modport slave (
    input  reg_wen, reg_waddr, reg_wdata, reg_ren, reg_raddr, sb_set, sb_addr,
    output reg_rdata, reg_rvalid, reg_pending, init_busy, regfile_interact
  );
endinterface

// File: rtl/regfile_mp_swc.sv
// Multi-read-port register file with write bypass, optional zero register, post-reset
// clear engine and per-entry pending scoreboard.
//
// state   | meaning
// ST_INIT | clear engine zeroes one entry per cycle, all requests ignored
// ST_RUN  | normal operation until the next reset
module regfile_mp_swc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             hclk,
  input logic             hrstn,
  regfile_mp_swc_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        ptr, ptr_nxt;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH*DATA_W-1:0]  shadow;
  logic [DEPTH-1:0]         pend;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_wa;
  logic [DATA_W-1:0]        mem_wd;
  logic                     sb_ok;
  logic [ADDR_W-1:0]        ra;
  logic [NUM_RD*DATA_W-1:0] rdata_nxt, rdata_q;
  logic [NUM_RD-1:0]        rvalid_nxt, rvalid_q;
  logic [NUM_RD-1:0]        pending_nxt, pending_q;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Single array write port shared by the clear engine and the functional write
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_wa    = bus.reg_waddr;
    mem_wd    = bus.reg_wdata;
    case (state)
      ST_INIT: begin
        mem_we  = 1'b1;
        mem_wa  = ptr;
        mem_wd  = '0;
        ptr_nxt = ptr + 1'b1;
        if (&ptr) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mem_we = bus.reg_wen && !(ZERO_REG != 0 && bus.reg_waddr == '0);
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) shadow <= '0;
    else if (mem_we) shadow[int'(mem_wa)*DATA_W +: DATA_W] <= mem_wd;
  end

  assign sb_ok = bus.sb_set && !(ZERO_REG != 0 && bus.sb_addr == '0);

  // Set is applied after clear so a new producer wins over a same-edge write
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      pend <= '0;
    end else if (state == ST_RUN) begin
      if (bus.reg_wen) pend[bus.reg_waddr] <= 1'b0;
      if (sb_ok)       pend[bus.sb_addr]   <= 1'b1;
    end
  end

  always_comb begin
    rdata_nxt   = '0;
    rvalid_nxt  = '0;
    pending_nxt = '0;
    ra          = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = bus.reg_raddr[p*ADDR_W +: ADDR_W];
      if (state == ST_RUN && bus.reg_ren[p]) begin
        rvalid_nxt[p] = 1'b1;
        if (ZERO_REG != 0 && ra == '0) begin
          rdata_nxt[p*DATA_W +: DATA_W] = '0;
        end else if (BYPASS != 0 && bus.reg_wen && ra == bus.reg_waddr) begin
          rdata_nxt[p*DATA_W +: DATA_W] = bus.reg_wdata;
        end else begin
          rdata_nxt[p*DATA_W +: DATA_W] = mem[ra];
          pending_nxt[p]                = pend[ra];
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      rdata_q   <= '0;
      rvalid_q  <= '0;
      pending_q <= '0;
    end else begin
      rdata_q   <= rdata_nxt;
      rvalid_q  <= rvalid_nxt;
      pending_q <= pending_nxt;
    end
  end

  assign bus.reg_rdata        = rdata_q;
  assign bus.reg_rvalid       = rvalid_q;
  assign bus.reg_pending      = pending_q;
  assign bus.init_busy        = (state == ST_INIT);
  assign bus.regfile_interact = shadow;
endmodule

// File: tb/tb_regfile_mp_swc.sv
// Scoreboarded bench: random and directed traffic on a default instance and a BYPASS=0 twin
// sharing the same stimulus, plus a small 4-port instance for the narrow configuration.
module tb_regfile_mp_swc;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic hclk  = 1'b0;
  logic hrstn = 1'b0;
  always #5 hclk = ~hclk;

  regfile_mp_swc_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ia ();
  regfile_mp_swc_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ib ();
  regfile_mp_swc_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4))   ic ();

  regfile_mp_swc #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1))
    dut_a (.hclk(hclk), .hrstn(hrstn), .bus(ia));
  regfile_mp_swc #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0))
    dut_b (.hclk(hclk), .hrstn(hrstn), .bus(ib));
  regfile_mp_swc #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1))
    dut_c (.hclk(hclk), .hrstn(hrstn), .bus(ic));

  assign ib.reg_wen   = ia.reg_wen;
  assign ib.reg_waddr = ia.reg_waddr;
  assign ib.reg_wdata = ia.reg_wdata;
  assign ib.reg_ren   = ia.reg_ren;
  assign ib.reg_raddr = ia.reg_raddr;
  assign ib.sb_set    = ia.sb_set;
  assign ib.sb_addr   = ia.sb_addr;

  typedef struct packed {
    logic [NR-1:0]    vld;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    pnd;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int          m_init = DEPTH;
  exp_t        qa[$];
  exp_t        qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wen, input int wa, input logic [31:0] wd, input bit [1:0] ren,
                       input int r0, input int r1, input bit sb, input int sa);
    ia.reg_wen   = wen;
    ia.reg_waddr = AW'(wa);
    ia.reg_wdata = wd;
    ia.reg_ren   = ren;
    ia.reg_raddr = {AW'(r1), AW'(r0)};
    ia.sb_set    = sb;
    ia.sb_addr   = AW'(sa);
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Expected responses come from the architectural rules; the model state advances at the edge.
  task automatic step();
    exp_t ea, eb;
    logic [AW-1:0] ra;
    ea = '0;
    eb = '0;
    if (hrstn && m_init == 0 && ia.reg_ren != 0) begin
      for (int p = 0; p < NR; p++) begin
        if (ia.reg_ren[p]) begin
          ra = ia.reg_raddr[p*AW +: AW];
          ea.vld[p] = 1'b1;
          eb.vld[p] = 1'b1;
          if (ra != 0) begin
            eb.data[p*DW +: DW] = m_mem[ra];
            eb.pnd[p]           = m_pend[ra];
            if (ia.reg_wen && ra == ia.reg_waddr) begin
              ea.data[p*DW +: DW] = ia.reg_wdata;
            end else begin
              ea.data[p*DW +: DW] = m_mem[ra];
              ea.pnd[p]           = m_pend[ra];
            end
          end
        end
      end
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge hclk);
    if (hrstn) begin
      if (m_init > 0) begin
        m_init--;
      end else begin
        if (ia.reg_wen) begin
          if (ia.reg_waddr != 0) m_mem[ia.reg_waddr] = ia.reg_wdata;
          m_pend[ia.reg_waddr] = 1'b0;
        end
        if (ia.sb_set && ia.sb_addr != 0) m_pend[ia.sb_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pend = '0;
    m_init = DEPTH;
  endtask

  task automatic do_reset();
    idle();
    step();
    hrstn = 1'b0;
    model_clear();
    #1;
    chk("rst_rvalid", {62'd0, ia.reg_rvalid}, 64'd0);
    chk("rst_rdata", ia.reg_rdata, 64'd0);
    chk("rst_pending", {62'd0, ia.reg_pending}, 64'd0);
    chk("rst_busy", {63'd0, ia.init_busy}, 64'd1);
    chk("rst_interact_zero", {63'd0, (ia.regfile_interact == '0)}, 64'd1);
    @(posedge hclk);
    #1;
    hrstn = 1'b1;
  endtask

  // Monitor: pops an expected entry whenever a DUT presents read data
  initial begin
    exp_t e;
    logic [DEPTH*DW-1:0] shadow_exp;
    forever begin
      @(negedge hclk);
      chk("init_busy", {63'd0, ia.init_busy}, {63'd0, (m_init > 0)});
      for (int i = 0; i < DEPTH; i++) shadow_exp[i*DW +: DW] = m_mem[i];
      checks++;
      if (ia.regfile_interact !== shadow_exp) begin
        errors++;
        for (int i = 0; i < DEPTH; i++)
          if (ia.regfile_interact[i*DW +: DW] !== shadow_exp[i*DW +: DW]) begin
            $display("FAIL interact entry %0d: got %h expected %h", i,
                     ia.regfile_interact[i*DW +: DW], shadow_exp[i*DW +: DW]);
            break;
          end
      end
      if (hrstn && ia.reg_rvalid != 0) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_rvalid", {62'd0, ia.reg_rvalid}, 64'd0);
        end else begin
          e = qa.pop_front();
          chk("a_rvalid", {62'd0, ia.reg_rvalid}, {62'd0, e.vld});
          chk("a_rdata", ia.reg_rdata, e.data);
          chk("a_pending", {62'd0, ia.reg_pending}, {62'd0, e.pnd});
        end
      end
      if (hrstn && ib.reg_rvalid != 0) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_rvalid", {62'd0, ib.reg_rvalid}, 64'd0);
        end else begin
          e = qb.pop_front();
          chk("b_rvalid", {62'd0, ib.reg_rvalid}, {62'd0, e.vld});
          chk("b_rdata", ib.reg_rdata, e.data);
          chk("b_pending", {62'd0, ib.reg_pending}, {62'd0, e.pnd});
        end
      end
    end
  end

  initial begin
    int na, nc, wa;
    idle();
    ic.reg_wen = 0; ic.reg_waddr = '0; ic.reg_wdata = '0;
    ic.reg_ren = '0; ic.reg_raddr = '0; ic.sb_set = 0; ic.sb_addr = '0;
    model_clear();
    repeat (2) @(posedge hclk);
    #1;
    hrstn = 1'b1;

    // T1/T6: clear engine duration for both geometries
    na = 0;
    nc = 0;
    for (int i = 0; i < 40; i++) begin
      if (ia.init_busy) na++;
      if (ic.init_busy) nc++;
      step();
    end
    chk("t1_busy_cycles", 64'(na), 64'd32);
    chk("t6_busy_cycles", 64'(nc), 64'd8);

    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 0, 2'b11, a, DEPTH - 1 - a, 0, 0);
      step();
    end

    // T6: four-port narrow instance
    for (int k = 1; k <= 4; k++) begin
      ic.reg_wen   = 1;
      ic.reg_waddr = 3'(k);
      ic.reg_wdata = 16'(16'h0101 * k);
      idle();
      step();
    end
    ic.reg_wen   = 0;
    ic.reg_ren   = 4'hF;
    ic.reg_raddr = {3'd4, 3'd3, 3'd2, 3'd1};
    step();
    ic.reg_ren = '0;
    chk("t6_rvalid", {60'd0, ic.reg_rvalid}, 64'hF);
    chk("t6_pending", {60'd0, ic.reg_pending}, 64'd0);
    for (int p = 0; p < 4; p++)
      chk($sformatf("t6_port%0d", p), {48'd0, ic.reg_rdata[p*16 +: 16]}, 64'(16'h0101 * (p + 1)));

    // T2
    drive(1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0); step();
    drive(0, 0, 0, 2'b01, 5, 0, 0, 0);            step();
    drive(1, 0, 32'h1234, 2'b00, 0, 0, 0, 0);     step();
    drive(0, 0, 0, 2'b11, 0, 5, 0, 0);            step();
    // T3
    drive(1, 7, 32'hA5A5A5A5, 2'b11, 7, 7, 0, 0); step();
    // T4
    drive(0, 0, 0, 2'b00, 0, 0, 1, 3);            step();
    drive(0, 0, 0, 2'b01, 3, 0, 0, 0);            step();
    drive(1, 3, 32'h11, 2'b11, 3, 3, 0, 0);       step();
    drive(1, 3, 32'h22, 2'b00, 0, 0, 1, 3);       step();
    drive(0, 0, 0, 2'b10, 0, 3, 0, 0);            step();
    // T5
    drive(1, 9, 32'h55, 2'b00, 0, 0, 0, 0);       step();
    drive(0, 0, 0, 2'b01, 9, 0, 0, 0);            step();
    do_reset();
    idle();
    repeat (DEPTH) step();
    drive(0, 0, 0, 2'b11, 9, 3, 0, 0);            step();

    // Random traffic concentrated on a few addresses to provoke bypass and scoreboard hits
    for (int i = 0; i < 600; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      drive(bit'($urandom_range(0, 1)), wa, $urandom, 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
      step();
      if (i == 300) do_reset();
    end
    idle();
    repeat (3) step();
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
